// File: rtl/bcd_cnt_pkg.sv
// Shared BCD digit type, limits and load sanitizing helper
// for the multi-digit BCD counter.
package bcd_cnt_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic bcd_digit_t bcd_sanitize(
    input bcd_digit_t d
  );
    return (d > BCD_MAX) ? BCD_MIN : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit cell; counts when step and carry_in are high,
// carry_out flags a terminal digit in the current direction.
module bcd_digit
  import bcd_cnt_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       step,
  input  logic       up,
  input  logic       carry_in,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       carry_out
);

  bcd_digit_t d_q;

  assign digit = d_q;
  assign carry_out = carry_in &
    (up ? (d_q == BCD_MAX) : (d_q == BCD_MIN));

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      d_q <= BCD_MIN;
    end else if (load) begin
      d_q <= bcd_sanitize(load_val);
    end else if (step && carry_in) begin
      if (up) begin
        d_q <= (d_q == BCD_MAX) ? BCD_MIN : d_q + 4'd1;
      end else begin
        d_q <= (d_q == BCD_MIN) ? BCD_MAX : d_q - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_counter_mdigit.sv
// Multi-digit up/down BCD counter with load and prescaled step.
// Define BCD_CNT_SATURATE_EN to hold at terminal count instead of wrapping.
module bcd_counter_mdigit
  import bcd_cnt_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000000
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                En,
  input  logic                Up,
  input  logic                Load,
  input  logic [4*DIGITS-1:0] LoadVal,
  output logic [4*DIGITS-1:0] O,
  output logic                Tick,
  output logic                Carry
);

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST =
    PW'(PRESCALE - 1);

  logic [PW-1:0]   pre_cnt;
  logic            tick;
  logic            wrap;
  logic            step;
  logic [DIGITS:0] chain;

  assign tick = (pre_cnt == PRE_LAST) && En && !Load;
  assign Tick = tick;

  // chain[DIGITS] is high when every digit is terminal
  assign chain[0] = 1'b1;
  assign wrap     = chain[DIGITS];

`ifdef BCD_CNT_SATURATE_EN
  assign step = tick & ~wrap;
`else
  assign step = tick;
`endif

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      pre_cnt <= '0;
    end else if (Load) begin
      pre_cnt <= '0;
    end else if (En) begin
      if (pre_cnt == PRE_LAST) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Carry <= 1'b0;
    end else begin
      Carry <= tick & wrap;
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit u_dig (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .step      (step),
      .up        (Up),
      .carry_in  (chain[i]),
      .load      (Load),
      .load_val  (LoadVal[4*i +: 4]),
      .digit     (O[4*i +: 4]),
      .carry_out (chain[i+1])
    );
  end

endmodule

// File: tb/tb_bcd_counter_mdigit.sv
// Scoreboard bench: two counter builds (2 digits /3, 3 digits /1)
// checked against a decimal-arithmetic model.
module tb_bcd_counter_mdigit;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        En = 1'b0;
  logic        Up = 1'b1;
  logic        Load = 1'b0;
  logic [11:0] lv = '0;

  logic [7:0]  o0;
  logic        t0, c0;
  logic [11:0] o1;
  logic        t1, c1;

  always #5 Clk = ~Clk;

  bcd_counter_mdigit #(.DIGITS(2), .PRESCALE(3)) dut0 (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .Up(Up),
    .Load(Load), .LoadVal(lv[7:0]),
    .O(o0), .Tick(t0), .Carry(c0)
  );

  bcd_counter_mdigit #(.DIGITS(3), .PRESCALE(1)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .Up(Up),
    .Load(Load), .LoadVal(lv),
    .O(o1), .Tick(t1), .Carry(c1)
  );

  typedef struct packed {
    logic [11:0] o1;
    logic [7:0]  o0;
    logic        c1;
    logic        c0;
  } st_t;

  st_t        sq[$];
  logic [1:0] tq[$];

  int nchk = 0;
  int nfail = 0;

  int unsigned m_val[2];
  int unsigned m_pre[2];
  bit          m_car[2];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               nm, $time, act, exp);
    end
  endtask

  function automatic int unsigned p10(input int n);
    int unsigned r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int unsigned lv_dec(input logic [11:0] v,
                                         input int n);
    int unsigned r = 0;
    for (int i = 0; i < n; i++) begin
      logic [3:0] nib;
      nib = v[4*i +: 4];
      if (nib <= 4'd9) r = r + int'(nib) * p10(i);
    end
    return r;
  endfunction

  function automatic logic [11:0] to_bcd(input int unsigned v,
                                         input int n);
    logic [11:0] r = '0;
    int unsigned x = v;
    for (int i = 0; i < n; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model(input int k, input logic rst,
                       input logic en, input logic up,
                       input logic ld, input logic [11:0] v,
                       output logic t);
    int nd, pk;
    int unsigned top;
    nd  = (k == 0) ? 2 : 3;
    pk  = (k == 0) ? 3 : 1;
    top = p10(nd) - 1;
    t = (m_pre[k] == pk - 1) && en && !ld;
    if (!rst) begin
      m_val[k] = 0; m_pre[k] = 0; m_car[k] = 0;
    end else if (ld) begin
      m_val[k] = lv_dec(v, nd); m_pre[k] = 0; m_car[k] = 0;
    end else begin
      m_car[k] = 0;
      if (en) m_pre[k] = (m_pre[k] + 1) % pk;
      if (t && up) begin
        if (m_val[k] == top) begin
          m_car[k] = 1;
`ifndef BCD_CNT_SATURATE_EN
          m_val[k] = 0;
`endif
        end else m_val[k] = m_val[k] + 1;
      end else if (t) begin
        if (m_val[k] == 0) begin
          m_car[k] = 1;
`ifndef BCD_CNT_SATURATE_EN
          m_val[k] = top;
`endif
        end else m_val[k] = m_val[k] - 1;
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic en,
                     input logic up, input logic ld,
                     input logic [11:0] v);
    logic e0, e1;
    st_t s;
    @(negedge Clk);
    Rst_n = rst; En = en; Up = up; Load = ld; lv = v;
    model(0, rst, en, up, ld, v, e0);
    model(1, rst, en, up, ld, v, e1);
    tq.push_back({e1, e0});
    s.o0 = to_bcd(m_val[0], 2)[7:0];
    s.o1 = to_bcd(m_val[1], 3);
    s.c0 = m_car[0];
    s.c1 = m_car[1];
    sq.push_back(s);
  endtask

  initial begin
    forever begin
      logic [1:0] et;
      @(negedge Clk);
      #2;
      if (tq.size() != 0) begin
        et = tq.pop_front();
        chk("tick0", {31'd0, t0}, {31'd0, et[0]});
        chk("tick1", {31'd0, t1}, {31'd0, et[1]});
      end
    end
  end

  initial begin
    forever begin
      st_t e;
      @(posedge Clk);
      #1;
      if (sq.size() != 0) begin
        e = sq.pop_front();
        chk("o0", {24'd0, o0}, {24'd0, e.o0});
        chk("carry0", {31'd0, c0}, {31'd0, e.c0});
        chk("o1", {20'd0, o1}, {20'd0, e.o1});
        chk("carry1", {31'd0, c1}, {31'd0, e.c1});
      end
    end
  end

  initial begin
    logic dir;
    logic [11:0] v;
    cyc(0, 0, 1, 0, 12'h000);
    cyc(0, 1, 1, 0, 12'h000);
    repeat (30) cyc(1, 1, 1, 0, 12'h000);
    cyc(1, 0, 1, 1, 12'h998);
    repeat (6) cyc(1, 1, 1, 0, 12'h000);
    cyc(1, 0, 0, 1, 12'h000);
    repeat (3) cyc(1, 1, 0, 0, 12'h000);
    cyc(1, 0, 0, 1, 12'h010);
    repeat (3) cyc(1, 1, 0, 0, 12'h000);
    cyc(1, 0, 1, 1, 12'hBA7);
    repeat (2) cyc(1, 1, 1, 0, 12'h000);
    cyc(1, 1, 1, 1, 12'h045);
    repeat (4) cyc(1, 1, 1, 0, 12'h000);
    cyc(1, 1, 1, 0, 12'h000);
    repeat (5) cyc(1, 0, 1, 0, 12'h000);
    repeat (4) cyc(1, 1, 1, 0, 12'h000);
    cyc(1, 0, 1, 1, 12'h157);
    cyc(1, 1, 1, 0, 12'h000);
    cyc(0, 1, 1, 0, 12'h000);
    repeat (3) cyc(1, 1, 1, 0, 12'h000);
    dir = 1'b1;
    repeat (800) begin
      if ($urandom_range(39) == 0) dir = ~dir;
      case ($urandom_range(4))
        0: v = 12'h999;
        1: v = 12'h998;
        2: v = 12'h000;
        3: v = 12'h001;
        default: v = 12'($urandom);
      endcase
      cyc($urandom_range(99) != 0, $urandom_range(7) != 0,
          dir, $urandom_range(24) == 0, v);
    end
    repeat (3) @(posedge Clk);
    #2;
    chk("drain", 32'(tq.size() + sq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
